// File: rtl/cache_arbiter_pkg.sv
// lc3b_types: shared word/line types and arbiter state/grant encodings
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] mem_bus;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: I-cache, D-cache and physical memory bus signals seen by the arbiter
interface cache_arbiter_if;
    import lc3b_types::*;
    logic     i_pmem_read;
    lc3b_word i_pmem_address;
    mem_bus   i_pmem_rdata;
    logic     i_pmem_resp;
    logic     d_pmem_read;
    logic     d_pmem_write;
    lc3b_word d_pmem_address;
    mem_bus   d_pmem_wdata;
    mem_bus   d_pmem_rdata;
    logic     d_pmem_resp;
    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    mem_bus   pmem_wdata;
    mem_bus   pmem_rdata;
    logic     pmem_resp;
    modport slave (
        input  i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );
    modport master (
        output i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter_control.sv
// arbiter_control: IDLE/SERVE_I/SERVE_D sequencing with round-robin or D-first tie breaking
module arbiter_control
    import lc3b_types::*;
#(
    parameter int D_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       pmem_resp,
    output arb_state_t state,
    output logic       load,
    output logic       win_d
);
    grant_t     last_grant;
    arb_state_t state_next;

    // pick the winner in IDLE; leave a serve state only when memory answers
    always_comb begin
        win_d = d_req && (!i_req || D_PRIORITY != 0 || last_grant == GRANT_I);
        load = state == IDLE && (i_req || d_req);
        state_next = load ? (win_d ? SERVE_D : SERVE_I) :
                     (state != IDLE && pmem_resp) ? IDLE : state;
    end

    // state register and record of who finished the last transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state <= state_next;
            if (pmem_resp && state == SERVE_I) last_grant <= GRANT_I;
            if (pmem_resp && state == SERVE_D) last_grant <= GRANT_D;
        end
    end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical memory port between the I-cache and D-cache
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int D_PRIORITY = 0
) (
    input logic           clk,
    input logic           rst,
    cache_arbiter_if.slave bus
);
    arb_state_t state;
    logic       load;
    logic       win_d;
    lc3b_word   hold_address;
    logic       hold_write;
    mem_bus     hold_wdata;

    arbiter_control #(.D_PRIORITY(D_PRIORITY)) u_control (
        .clk       (clk),
        .rst       (rst),
        .i_req     (bus.i_pmem_read),
        .d_req     (bus.d_pmem_read || bus.d_pmem_write),
        .pmem_resp (bus.pmem_resp),
        .state     (state),
        .load      (load),
        .win_d     (win_d)
    );

    // capture the winner's request so the memory side is immune to requester changes
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_address <= '0;
            hold_write <= 1'b0;
            hold_wdata <= '0;
        end else if (load) begin
            hold_address <= win_d ? bus.d_pmem_address : bus.i_pmem_address;
            hold_write <= win_d && bus.d_pmem_write;
            hold_wdata <= (win_d && bus.d_pmem_write) ? bus.d_pmem_wdata : '0;
        end
    end

    // memory command from the hold registers; responses routed to the owner only
    always_comb begin
        bus.pmem_read = state != IDLE && !hold_write;
        bus.pmem_write = state != IDLE && hold_write;
        bus.pmem_address = hold_address;
        bus.pmem_wdata = hold_wdata;
        bus.i_pmem_resp = state == SERVE_I && bus.pmem_resp;
        bus.d_pmem_resp = state == SERVE_D && bus.pmem_resp;
        bus.i_pmem_rdata = bus.pmem_rdata;
        bus.d_pmem_rdata = bus.pmem_rdata;
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed checks of round-robin (a) and D-priority (b) arbiters
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    cache_arbiter_if a ();
    cache_arbiter_if b ();

    cache_arbiter #(.D_PRIORITY(0)) u_rr (.clk(clk), .rst(rst), .bus(a));
    cache_arbiter #(.D_PRIORITY(1)) u_dp (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        a.i_pmem_read = 0; a.i_pmem_address = 0; a.d_pmem_read = 0; a.d_pmem_write = 0;
        a.d_pmem_address = 0; a.d_pmem_wdata = 0; a.pmem_rdata = 0; a.pmem_resp = 0;
        b.i_pmem_read = 0; b.i_pmem_address = 0; b.d_pmem_read = 0; b.d_pmem_write = 0;
        b.d_pmem_address = 0; b.d_pmem_wdata = 0; b.pmem_rdata = 0; b.pmem_resp = 0;
        step(); step();
        #1;
        check("rst_read", a.pmem_read, 0);
        check("rst_write", a.pmem_write, 0);
        check("rst_iresp", a.i_pmem_resp, 0);
        check("rst_dresp", a.d_pmem_resp, 0);
        check("rst_addr", a.pmem_address, 0);
        // lone I read, memory answers on the third serve cycle
        step(); rst = 0; a.i_pmem_read = 1; a.i_pmem_address = 16'h1230;
        #1 check("i_idle_read", a.pmem_read, 0);
        step(); a.i_pmem_read = 0; a.i_pmem_address = 16'h0000;
        #1 check("i_c1_read", a.pmem_read, 1);
        check("i_c1_addr", a.pmem_address, 16'h1230);
        check("i_c1_iresp", a.i_pmem_resp, 0);
        step();
        #1 check("i_c2_read", a.pmem_read, 1);
        step(); a.pmem_resp = 1; a.pmem_rdata = {16{8'hA5}};
        #1 check("i_c3_read", a.pmem_read, 1);
        check("i_c3_iresp", a.i_pmem_resp, 1);
        check("i_c3_rdata", a.i_pmem_rdata, {16{8'hA5}});
        check("i_c3_dresp", a.d_pmem_resp, 0);
        step(); a.pmem_resp = 0;
        #1 check("i_after_read", a.pmem_read, 0);
        check("i_after_iresp", a.i_pmem_resp, 0);
        // stray memory response while idle is not forwarded
        step(); a.pmem_resp = 1;
        #1 check("idle_resp_i", a.i_pmem_resp, 0);
        check("idle_resp_d", a.d_pmem_resp, 0);
        step(); a.pmem_resp = 0;
        #1 check("idle_resp_stay", a.pmem_read, 0);
        // lone D write
        step(); a.d_pmem_write = 1; a.d_pmem_address = 16'h4000; a.d_pmem_wdata = {16{8'h11}};
        step(); a.d_pmem_write = 0; a.d_pmem_wdata = 0;
        #1 check("dw_write", a.pmem_write, 1);
        check("dw_read", a.pmem_read, 0);
        check("dw_addr", a.pmem_address, 16'h4000);
        check("dw_wdata", a.pmem_wdata, {16{8'h11}});
        step(); a.pmem_resp = 1;
        #1 check("dw_write2", a.pmem_write, 1);
        check("dw_dresp", a.d_pmem_resp, 1);
        check("dw_iresp", a.i_pmem_resp, 0);
        step(); a.pmem_resp = 0;
        #1 check("dw_after", a.pmem_write, 0);
        // read and write together resolve as write; address change mid-service ignored
        step(); a.d_pmem_read = 1; a.d_pmem_write = 1; a.d_pmem_address = 16'h4000; a.d_pmem_wdata = {16{8'h22}};
        step(); a.d_pmem_address = 16'h5000;
        #1 check("rw_write", a.pmem_write, 1);
        check("rw_read", a.pmem_read, 0);
        check("addr_hold1", a.pmem_address, 16'h4000);
        step();
        #1 check("addr_hold2", a.pmem_address, 16'h4000);
        step(); a.pmem_resp = 1; a.d_pmem_read = 0; a.d_pmem_write = 0;
        #1 check("addr_hold3", a.pmem_address, 16'h4000);
        check("rw_dresp", a.d_pmem_resp, 1);
        step(); a.pmem_resp = 0;
        // ties from reset, round robin
        rst = 1;
        step(); rst = 0; a.i_pmem_read = 1; a.i_pmem_address = 16'h1000; a.d_pmem_read = 1; a.d_pmem_address = 16'h2000;
        #1 check("tie_idle", a.pmem_read, 0);
        step(); a.pmem_resp = 1;
        #1 check("tie1_addr", a.pmem_address, 16'h2000);
        check("tie1_dresp", a.d_pmem_resp, 1);
        check("tie1_iresp", a.i_pmem_resp, 0);
        step(); a.pmem_resp = 0; a.d_pmem_address = 16'h2200;
        #1 check("tie1_gap", a.pmem_read, 0);
        step(); a.pmem_resp = 1; a.i_pmem_read = 0;
        #1 check("tie2_addr", a.pmem_address, 16'h1000);
        check("tie2_iresp", a.i_pmem_resp, 1);
        check("tie2_dresp", a.d_pmem_resp, 0);
        step(); a.pmem_resp = 0;
        #1 check("tie2_gap", a.pmem_read, 0);
        step(); a.pmem_resp = 1; a.d_pmem_read = 0;
        #1 check("tie3_addr", a.pmem_address, 16'h2200);
        check("tie3_dresp", a.d_pmem_resp, 1);
        step(); a.pmem_resp = 0;
        // reset in the middle of an I transfer
        step(); a.i_pmem_read = 1; a.i_pmem_address = 16'h3000;
        step(); a.i_pmem_read = 0; rst = 1;
        #1 check("rstmid_read", a.pmem_read, 1);
        check("rstmid_iresp", a.i_pmem_resp, 0);
        step(); rst = 0; a.pmem_resp = 1;
        #1 check("rstmid_after_read", a.pmem_read, 0);
        check("rstmid_after_iresp", a.i_pmem_resp, 0);
        step(); a.pmem_resp = 0; a.d_pmem_read = 1; a.d_pmem_address = 16'h6000;
        step(); a.d_pmem_read = 0; a.pmem_resp = 1;
        #1 check("rstmid_d_read", a.pmem_read, 1);
        check("rstmid_d_addr", a.pmem_address, 16'h6000);
        check("rstmid_d_dresp", a.d_pmem_resp, 1);
        step(); a.pmem_resp = 0;
        // D priority: three ties all go to D, then I
        rst = 1;
        step(); rst = 0; b.i_pmem_read = 1; b.i_pmem_address = 16'h7000; b.d_pmem_read = 1; b.d_pmem_address = 16'h8000;
        for (int k = 0; k < 3; k++) begin
            step(); b.pmem_resp = 1;
            if (k == 2) b.d_pmem_read = 0;
            #1 check("dp_addr", b.pmem_address, 16'h8000);
            check("dp_dresp", b.d_pmem_resp, 1);
            check("dp_iresp", b.i_pmem_resp, 0);
            step(); b.pmem_resp = 0;
            #1 check("dp_gap", b.pmem_read, 0);
        end
        step(); b.pmem_resp = 1; b.i_pmem_read = 0;
        #1 check("dp_i_addr", b.pmem_address, 16'h7000);
        check("dp_i_iresp", b.i_pmem_resp, 1);
        check("dp_i_dresp", b.d_pmem_resp, 0);
        step(); b.pmem_resp = 0;
        #1 check("dp_end", b.pmem_read, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter D_PRIORITY, default 0: 0 = alternate on tie (round-robin), 1 = D side always wins a tie.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_pmem_read  in  1  I-cache line-fill request.
REQ-005 i_pmem_address  in  lc3b_word  I-cache line address.
REQ-006 i_pmem_rdata  out  mem_bus  line data to I-cache.
REQ-007 i_pmem_resp  out  1  I-cache transfer complete.
REQ-008 d_pmem_read / d_pmem_write  in  1 each  D-cache fill / write-back request.
REQ-009 d_pmem_address  in  lc3b_word; d_pmem_wdata  in  mem_bus  D-cache address and write-back line.
REQ-010 d_pmem_rdata  out  mem_bus; d_pmem_resp  out  1  D-cache return path.
REQ-011 pmem_read / pmem_write  out  1 each  physical memory command.
REQ-012 pmem_address  out  lc3b_word; pmem_wdata  out  mem_bus  physical memory address and write line.
REQ-013 pmem_rdata  in  mem_bus; pmem_resp  in  1  physical memory return.

Function
REQ-014 FSM states IDLE, SERVE_I, SERVE_D, held in one state register.
REQ-015 In IDLE, pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are all 0.
REQ-016 In IDLE: I request only -> SERVE_I next cycle; D request (read or write) only -> SERVE_D next cycle; neither -> stay IDLE.
REQ-017 Both requesting in IDLE: D_PRIORITY=1 -> SERVE_D; D_PRIORITY=0 -> the side not granted last (last_grant register, reset value I, so the first tie goes to D).
REQ-018 On IDLE exit, latch the winner's address, command (read/write) and, for D write, wdata into hold registers; pmem_* outputs drive only from hold registers.
REQ-019 In SERVE_x: pmem_read or pmem_write (per latched command) held at 1 every cycle until pmem_resp=1; requester inputs ignored meanwhile.
REQ-020 d_pmem_read=d_pmem_write=1 together is resolved as write.
REQ-021 On pmem_resp=1 in SERVE_x, the owner's *_resp = 1 in the same cycle (combinational); non-owner resp = 0; next state IDLE; last_grant updated to the owner.
REQ-022 i_pmem_rdata and d_pmem_rdata are combinational copies of pmem_rdata at all times; validity is defined only by the matching resp.
REQ-023 Minimum service turnaround: request seen in IDLE cycle N, pmem command asserted cycle N+1, owner resp in the cycle pmem_resp arrives; next arbitration earliest in the cycle after resp.
REQ-024 pmem_resp=1 while in IDLE is ignored; no resp is forwarded.
REQ-025 A request arriving while the other side is served waits; it is not dropped and is granted in the next IDLE cycle, so neither side waits more than one other transfer (D_PRIORITY=0).
REQ-026 A requester deasserting before its resp does not abort the transfer; the transfer completes and resp is still pulsed.

Reset
REQ-027 rst=1 at a clock edge -> state IDLE, last_grant = I, hold registers 0; all outputs derived from IDLE are 0 from the following cycle.
REQ-028 rst asserted mid-transfer abandons the transfer: no resp is forwarded for it, and the first cycle after rst deasserts is IDLE.

Structure
REQ-029 The arbiter state enum and the grant-side enum (I/D) are declared in lc3b_types alongside mem_bus and lc3b_word.
REQ-030 Sub-module arbiter_control (FSM + last_grant); the hold registers and output muxing are inline in cache_arbiter.

Verification
REQ-031 Lone I read of 0x1230; memory responds after 3 cycles with line 0xA5..A5 -> pmem_read=1 for 3 cycles, pmem_address=0x1230, i_pmem_resp pulses 1 cycle with the data, d_pmem_resp stays 0.
REQ-032 Lone D write to 0x4000 with wdata 0x1111..11 -> pmem_write=1, pmem_wdata=0x1111..11 until resp, d_pmem_resp 1 cycle.
REQ-033 I and D (D read) asserted in the same cycle from reset, D_PRIORITY=0 -> D served first, then I with no idle gap beyond one IDLE cycle. A second simultaneous tie -> I served first.
REQ-034 D_PRIORITY=1, three back-to-back ties -> D served all three times; I served only once D is idle.
REQ-035 D requester changes d_pmem_address from 0x4000 to 0x5000 mid-service -> pmem_address stays 0x4000 until resp.
REQ-036 rst pulsed during SERVE_I before pmem_resp -> no i_pmem_resp, pmem_read=0 in the cycle after reset, and a fresh D request is then granted normally.
